// File: rtl/demorgan_pkg.sv
// Shared types, widths and the reference model for the NAND sweep controller.
package demorgan_pkg;

    localparam int VEC_W    = 2;
    localparam int ERR_W    = 8;
    localparam int ERR_MAX  = 255;
    localparam int SETTLE_W = 4;
    localparam int PASS_W   = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_APPLY  = 3'd1,
        S_SETTLE = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4
    } sweep_state_t;

    // De Morgan equivalent of the gate under test: ~(a&b) == ~a | ~b
    function automatic logic demorgan_ref(input logic a, input logic b);
        return ~a | ~b;
    endfunction

endpackage

// File: rtl/demorgan_sweep_ctrl_if.sv
// Board-side bundle between the sweep controller, the gate and the status LEDs.
interface demorgan_sweep_ctrl_if;
    import demorgan_pkg::*;

    logic                 start;
    logic                 e_i;
    logic                 a_o;
    logic                 b_o;
    logic                 vec_valid;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [ERR_W-1:0]     err_cnt;
    logic                 first_fail_valid;
    logic [VEC_W-1:0]     first_fail_vec;

    // Board side: start button and gate output in, status out
    modport master (
        output start,
        output e_i,
        input  a_o,
        input  b_o,
        input  vec_valid,
        input  busy,
        input  done,
        input  pass,
        input  err_cnt,
        input  first_fail_valid,
        input  first_fail_vec
    );

    // Controller side
    modport slave (
        input  start,
        input  e_i,
        output a_o,
        output b_o,
        output vec_valid,
        output busy,
        output done,
        output pass,
        output err_cnt,
        output first_fail_valid,
        output first_fail_vec
    );

endinterface

// File: rtl/demorgan_nand_unit.sv
// Gate under test on the lab board: plain 2-input NAND.
module demorgan_nand_unit (
    input  logic i_a,
    input  logic i_b,
    output logic o_e
);

    assign o_e = ~(i_a & i_b);

endmodule

// File: rtl/demorgan_sweep_ctrl.sv
// Sweep controller: drives all four {a,b} vectors onto the gate, waits a
// settle time, compares the gate output to ~a|~b and accumulates results.
//
// state  | meaning
// IDLE   | waiting for start, results held
// APPLY  | vector on a_o/b_o, settle timer loaded
// SETTLE | timer counting down, inputs stable
// CHECK  | e_i compared, next vector / pass / finish chosen
// DONE   | one-cycle done pulse, pass flag final
module demorgan_sweep_ctrl
    import demorgan_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 1,
    parameter int unsigned PASSES     = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    demorgan_sweep_ctrl_if.slave bus
);

    sweep_state_t          r_state;
    logic [VEC_W-1:0]      r_vec;
    logic [PASS_W-1:0]     r_pass_idx;
    logic [SETTLE_W-1:0]   r_settle;
    logic                  r_vec_valid;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_pass;
    logic [ERR_W-1:0]      r_err;
    logic                  r_ff_valid;
    logic [VEC_W-1:0]      r_ff_vec;

    logic                  w_mismatch;
    logic [ERR_W-1:0]      w_err_next;
    logic                  w_last_vec;
    logic                  w_last_pass;

    // Compare the gate output against the De Morgan form of the held vector
    always_comb begin
        w_mismatch  = (bus.e_i != demorgan_ref(r_vec[1], r_vec[0]));
        w_err_next  = r_err;
        if (w_mismatch && (r_err != ERR_W'(ERR_MAX))) begin
            w_err_next = r_err + 1'b1;
        end
        w_last_vec  = (r_vec == VEC_W'(3));
        w_last_pass = (r_pass_idx >= PASS_W'(PASSES - 1));
    end

    // Sequencing FSM; the vector register doubles as a_o/b_o so the vector is
    // already on the pins during the APPLY cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_vec       <= '0;
            r_pass_idx  <= '0;
            r_settle    <= '0;
            r_vec_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err       <= '0;
            r_ff_valid  <= 1'b0;
            r_ff_vec    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_err       <= '0;
                        r_ff_valid  <= 1'b0;
                        r_ff_vec    <= '0;
                        r_pass      <= 1'b0;
                        r_vec       <= '0;
                        r_pass_idx  <= '0;
                        r_vec_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_APPLY;
                    end
                end
                S_APPLY: begin
                    r_settle <= SETTLE_W'(SETTLE_CYC);
                    r_state  <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_settle <= SETTLE_W'(1)) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_settle <= r_settle - 1'b1;
                    end
                end
                S_CHECK: begin
                    r_err <= w_err_next;
                    if (w_mismatch && !r_ff_valid) begin
                        r_ff_valid <= 1'b1;
                        r_ff_vec   <= r_vec;
                    end
                    if (!w_last_vec) begin
                        r_vec   <= r_vec + 1'b1;
                        r_state <= S_APPLY;
                    end else if (!w_last_pass) begin
                        r_vec      <= '0;
                        r_pass_idx <= r_pass_idx + 1'b1;
                        r_state    <= S_APPLY;
                    end else begin
                        r_vec_valid <= 1'b0;
                        r_done      <= 1'b1;
                        r_pass      <= (w_err_next == '0);
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.a_o              = r_vec[1];
    assign bus.b_o              = r_vec[0];
    assign bus.vec_valid        = r_vec_valid;
    assign bus.busy             = r_busy;
    assign bus.done             = r_done;
    assign bus.pass             = r_pass;
    assign bus.err_cnt          = r_err;
    assign bus.first_fail_valid = r_ff_valid;
    assign bus.first_fail_vec   = r_ff_vec;

endmodule

// File: tb/tb_demorgan_sweep_ctrl.sv
// Scoreboard bench: stimulus pushes expected run results and vectors, a
// negedge monitor pops and compares whenever a DUT pulses done or shows a
// new vector.
module tb_demorgan_sweep_ctrl;
    import demorgan_pkg::*;

    typedef struct {
        logic [7:0] err;
        logic       pass;
        logic       ffv;
        logic [1:0] ffvec;
        int         n0;
        int         dcyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   mode0 = 0;
    logic w_nand;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int   qv[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    demorgan_sweep_ctrl_if if0();
    demorgan_sweep_ctrl_if if1();
    demorgan_sweep_ctrl_if if2();

    demorgan_sweep_ctrl u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    demorgan_sweep_ctrl #(.SETTLE_CYC(3)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    demorgan_sweep_ctrl #(.PASSES(70))    u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    demorgan_nand_unit u_gate (.i_a(if0.a_o), .i_b(if0.b_o), .o_e(w_nand));

    assign if0.e_i = (mode0 == 0) ? w_nand : (mode0 == 1) ? 1'b1 : (if0.a_o & if0.b_o);
    assign if1.e_i = if1.a_o & if1.b_o;
    assign if2.e_i = if2.a_o & if2.b_o;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input int err, input bit p, input bit ffv,
                                input int ffvec, input int dcyc);
        exp_t e;
        e.err = 8'(err); e.pass = p; e.ffv = ffv; e.ffvec = 2'(ffvec);
        e.n0 = 0; e.dcyc = dcyc;
        return e;
    endfunction

    task automatic cmp(input string t, input exp_t e, input logic [7:0] err,
                       input logic p, input logic ffv, input logic [1:0] ffvec,
                       input logic busy, input logic vv);
        chk({t, "_done_cycle"}, cyc - e.n0 + 1, e.dcyc);
        chk({t, "_err_cnt"}, int'(err), int'(e.err));
        chk({t, "_pass"}, int'(p), int'(e.pass));
        chk({t, "_ff_valid"}, int'(ffv), int'(e.ffv));
        chk({t, "_ff_vec"}, int'(ffvec), int'(e.ffvec));
        chk({t, "_busy_at_done"}, int'(busy), 1);
        chk({t, "_vec_valid_at_done"}, int'(vv), 0);
    endtask

    task automatic chk_zero(input string t, input logic a, input logic b,
                            input logic vv, input logic busy, input logic dn,
                            input logic p, input logic [7:0] err,
                            input logic ffv, input logic [1:0] ffvec);
        chk({t, "_rst_outputs"},
            int'({a, b, vv, busy, dn, p, err, ffv, ffvec}), 0);
        chk({t, "_rst_err_cnt"}, int'(err), 0);
    endtask

    // Result monitor: one expected entry per done pulse
    always @(negedge clk) begin
        exp_t e;
        if (if0.done) begin
            if (q0.size() == 0) chk("u0_unexpected_done", int'(if0.done), 0);
            else begin
                e = q0.pop_front();
                cmp("u0", e, if0.err_cnt, if0.pass, if0.first_fail_valid,
                    if0.first_fail_vec, if0.busy, if0.vec_valid);
            end
        end
        if (if1.done) begin
            if (q1.size() == 0) chk("u1_unexpected_done", int'(if1.done), 0);
            else begin
                e = q1.pop_front();
                cmp("u1", e, if1.err_cnt, if1.pass, if1.first_fail_valid,
                    if1.first_fail_vec, if1.busy, if1.vec_valid);
            end
        end
        if (if2.done) begin
            if (q2.size() == 0) chk("u2_unexpected_done", int'(if2.done), 0);
            else begin
                e = q2.pop_front();
                cmp("u2", e, if2.err_cnt, if2.pass, if2.first_fail_valid,
                    if2.first_fail_vec, if2.busy, if2.vec_valid);
            end
        end
    end

    // Vector monitor on u0: every newly presented vector is popped and compared
    logic       pv = 1'b0;
    logic [1:0] pvec = 2'b00;
    always @(negedge clk) begin
        if (if0.vec_valid && (!pv || {if0.a_o, if0.b_o} != pvec)) begin
            if (qv.size() == 0) chk("u0_vec_extra", int'({if0.a_o, if0.b_o}) + 4, 0);
            else chk("u0_vec", int'({if0.a_o, if0.b_o}), qv.pop_front());
        end
        pv   = if0.vec_valid;
        pvec = {if0.a_o, if0.b_o};
    end

    function automatic int qsize(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic set_start(input int d, input logic v);
        case (d)
            0:       if0.start = v;
            1:       if1.start = v;
            default: if2.start = v;
        endcase
    endtask

    // Pulse start for one edge; returns during cycle 1 of the run
    task automatic launch(input int d, input bit push, input exp_t e, output int n0);
        @(negedge clk);
        set_start(d, 1'b1);
        @(posedge clk);
        #1;
        n0 = cyc;
        e.n0 = n0;
        if (push) begin
            case (d)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
        @(negedge clk);
        set_start(d, 1'b0);
    endtask

    task automatic drain(input int d, input int limit);
        int k = 0;
        while ((qsize(d) > 0 || (d == 0 && qv.size() > 0)) && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("u%0d_drain_timeout", d), qsize(d), 0);
        if (d == 0) chk("u0_vec_drain", qv.size(), 0);
        q0.delete(); q1.delete(); q2.delete(); qv.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic push_vecs(input int n);
        for (int i = 0; i < n; i++) qv.push_back(i % 4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=%0d required=<%0d", cyc, 20000);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        exp_t e;
        if0.start = 1'b0; if1.start = 1'b0; if2.start = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("u0", if0.a_o, if0.b_o, if0.vec_valid, if0.busy, if0.done,
                 if0.pass, if0.err_cnt, if0.first_fail_valid, if0.first_fail_vec);
        chk_zero("u1", if1.a_o, if1.b_o, if1.vec_valid, if1.busy, if1.done,
                 if1.pass, if1.err_cnt, if1.first_fail_valid, if1.first_fail_vec);
        chk_zero("u2", if2.a_o, if2.b_o, if2.vec_valid, if2.busy, if2.done,
                 if2.pass, if2.err_cnt, if2.first_fail_valid, if2.first_fail_vec);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Correct NAND, defaults
        mode0 = 0;
        push_vecs(4);
        launch(0, 1'b1, mk(0, 1'b1, 1'b0, 0, 13), n0);
        drain(0, 40);
        repeat (4) @(negedge clk);
        chk("u0_pass_hold", int'(if0.pass), 1);
        chk("u0_busy_idle", int'(if0.busy), 0);

        // Output stuck at 1: only vector 11 fails
        mode0 = 1;
        push_vecs(4);
        launch(0, 1'b1, mk(1, 1'b0, 1'b1, 3, 13), n0);
        drain(0, 40);
        chk("u0_err_hold", int'(if0.err_cnt), 1);

        // AND gate, SETTLE_CYC=3
        launch(1, 1'b1, mk(4, 1'b0, 1'b1, 0, 21), n0);
        drain(1, 60);

        // AND gate, 70 passes: 280 mismatches saturate at 255
        launch(2, 1'b1, mk(255, 1'b0, 1'b1, 0, 841), n0);
        drain(2, 1000);

        // Start re-pulsed mid-run is ignored
        mode0 = 0;
        push_vecs(4);
        launch(0, 1'b1, mk(0, 1'b1, 1'b0, 0, 13), n0);
        repeat (3) @(negedge clk);
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        drain(0, 40);

        // Start held through DONE launches a second run that re-clears results
        mode0 = 1;
        push_vecs(8);
        @(negedge clk);
        if0.start = 1'b1;
        @(posedge clk);
        #1;
        n0 = cyc;
        e = mk(1, 1'b0, 1'b1, 3, 13); e.n0 = n0;      q0.push_back(e);
        e = mk(1, 1'b0, 1'b1, 3, 13); e.n0 = n0 + 14; q0.push_back(e);
        repeat (16) @(negedge clk);
        if0.start = 1'b0;
        drain(0, 60);

        // Reset at cycle 6 abandons the run with no done pulse
        mode0 = 0;
        push_vecs(2);
        launch(0, 1'b0, mk(0, 1'b0, 1'b0, 0, 0), n0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_zero("u0_midrun", if0.a_o, if0.b_o, if0.vec_valid, if0.busy, if0.done,
                 if0.pass, if0.err_cnt, if0.first_fail_valid, if0.first_fail_vec);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("u0_midrun_vec_left", qv.size(), 0);
        qv.delete();

        // Fresh run after the aborted one
        push_vecs(4);
        launch(0, 1'b1, mk(0, 1'b1, 1'b0, 0, 13), n0);
        drain(0, 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
